// File: rtl/prf_pkg.sv
// Shared defaults, id-width helper and typedefs for the multi-port PRF.
// Optional build macro: PRF_ZERO_REG_EN (physical register 0 hardwired to zero).
package prf_pkg;

    localparam int PRF_SIZE_DEF = 32;
    localparam int DATA_W_DEF   = 8;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WB_DEF   = 2;

`ifdef PRF_ZERO_REG_EN
    localparam bit PRF_ZERO_REG = 1'b1;
`else
    localparam bit PRF_ZERO_REG = 1'b0;
`endif

    function automatic int prf_id_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    typedef logic [prf_id_w(PRF_SIZE_DEF)-1:0] prf_id_t;
    typedef logic [DATA_W_DEF-1:0]             prf_data_t;

endpackage

// File: rtl/prf_read_port.sv
// One registered PRF read port: writeback bypass mux followed by the output register.
module prf_read_port
    import prf_pkg::*;
#(
    parameter  int PRF_SIZE = PRF_SIZE_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_WB   = NUM_WB_DEF,
    localparam int ID_W     = prf_id_w(PRF_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_rd_req,
    input  logic [ID_W-1:0]                  i_rd_id,
    input  logic [PRF_SIZE-1:0][DATA_W-1:0]  i_rf,
    input  logic [NUM_WB-1:0]                i_wb_ena,
    input  logic [NUM_WB-1:0][ID_W-1:0]      i_wb_id,
    input  logic [NUM_WB-1:0][DATA_W-1:0]    i_wb_val,
    output logic                             o_rd_valid,
    output logic [DATA_W-1:0]                o_rd_val
);

    logic [DATA_W-1:0] w_byp;
    logic              r_valid;
    logic [DATA_W-1:0] r_val;

    // Ascending scan so the highest-index matching writeback wins.
    always_comb begin
        w_byp = i_rf[i_rd_id];
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (i_wb_ena[i] && (i_wb_id[i] == i_rd_id))
                w_byp = i_wb_val[i];
        end
        if (PRF_ZERO_REG && (i_rd_id == '0))
            w_byp = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_val   <= '0;
        end else begin
            r_valid <= i_rd_req;
            r_val   <= i_rd_req ? w_byp : '0;
        end
    end

    assign o_rd_valid = r_valid;
    assign o_rd_val   = r_val;

endmodule

// File: rtl/prf_multiport.sv
// Multi-port physical register file: storage, ready tracking, CDB lanes and NUM_RD read ports.
// Optional build macro: PRF_ZERO_REG_EN (physical register 0 hardwired to zero).
module prf_multiport
    import prf_pkg::*;
#(
    parameter  int PRF_SIZE = PRF_SIZE_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_RD   = NUM_RD_DEF,
    parameter  int NUM_WB   = NUM_WB_DEF,
    localparam int ID_W     = prf_id_w(PRF_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0]              rd_req,
    input  logic [NUM_RD-1:0][ID_W-1:0]    rd_id,
    output logic [NUM_RD-1:0]              rd_valid,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_val,
    input  logic [NUM_WB-1:0]              wb_ena,
    input  logic [NUM_WB-1:0][ID_W-1:0]    wb_id,
    input  logic [NUM_WB-1:0][DATA_W-1:0]  wb_val,
    input  logic [NUM_WB-1:0]              free_ena,
    input  logic [NUM_WB-1:0][ID_W-1:0]    free_id,
    output logic [PRF_SIZE-1:0]            ready_regs,
    output logic [NUM_WB-1:0]              cdb_valid,
    output logic [NUM_WB-1:0][ID_W-1:0]    cdb_id,
    output logic [NUM_WB-1:0][DATA_W-1:0]  cdb_val
);

    logic [PRF_SIZE-1:0][DATA_W-1:0] r_rf;
    logic [PRF_SIZE-1:0]             r_ready;
    logic [NUM_WB-1:0]               r_cdb_valid;
    logic [NUM_WB-1:0][ID_W-1:0]     r_cdb_id;
    logic [NUM_WB-1:0][DATA_W-1:0]   r_cdb_val;
    logic [NUM_WB-1:0]               w_wb_zero;
    logic [NUM_WB-1:0]               w_free_zero;

    always_comb begin
        w_wb_zero   = '0;
        w_free_zero = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            w_wb_zero[i]   = PRF_ZERO_REG && (wb_id[i] == '0);
            w_free_zero[i] = PRF_ZERO_REG && (free_id[i] == '0);
        end
    end

    // Frees are scheduled before writes so a same-cycle write to the same id leaves it ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf        <= '0;
            r_ready     <= '1;
            r_cdb_valid <= '0;
            r_cdb_id    <= '0;
            r_cdb_val   <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WB; j++) begin
                if (free_ena[j] && !w_free_zero[j])
                    r_ready[free_id[j]] <= 1'b0;
            end
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_ena[i]) begin
                    r_ready[wb_id[i]] <= 1'b1;
                    if (!w_wb_zero[i])
                        r_rf[wb_id[i]] <= wb_val[i];
                end
                r_cdb_valid[i] <= wb_ena[i];
                r_cdb_id[i]    <= wb_ena[i] ? wb_id[i] : '0;
                r_cdb_val[i]   <= (wb_ena[i] && !w_wb_zero[i]) ? wb_val[i] : '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        prf_read_port #(
            .PRF_SIZE (PRF_SIZE),
            .DATA_W   (DATA_W),
            .NUM_WB   (NUM_WB)
        ) u_rd (
            .clk        (clk),
            .rst        (rst),
            .i_rd_req   (rd_req[g]),
            .i_rd_id    (rd_id[g]),
            .i_rf       (r_rf),
            .i_wb_ena   (wb_ena),
            .i_wb_id    (wb_id),
            .i_wb_val   (wb_val),
            .o_rd_valid (rd_valid[g]),
            .o_rd_val   (rd_val[g])
        );
    end

    assign ready_regs = r_ready;
    assign cdb_valid  = r_cdb_valid;
    assign cdb_id     = r_cdb_id;
    assign cdb_val    = r_cdb_val;

endmodule

// File: tb/tb_prf_multiport.sv
// Self-checking bench for prf_multiport: directed scenarios then random traffic against an array model.
module tb_prf_multiport;
    import prf_pkg::*;

    localparam int NPR = 32;
    localparam int DW  = 8;
    localparam int NRD = 2;
    localparam int NWB = 2;
    localparam int IW  = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NRD-1:0]           rd_req;
    logic [NRD-1:0][IW-1:0]   rd_id;
    logic [NRD-1:0]           rd_valid;
    logic [NRD-1:0][DW-1:0]   rd_val;
    logic [NWB-1:0]           wb_ena;
    logic [NWB-1:0][IW-1:0]   wb_id;
    logic [NWB-1:0][DW-1:0]   wb_val;
    logic [NWB-1:0]           free_ena;
    logic [NWB-1:0][IW-1:0]   free_id;
    logic [NPR-1:0]           ready_regs;
    logic [NWB-1:0]           cdb_valid;
    logic [NWB-1:0][IW-1:0]   cdb_id;
    logic [NWB-1:0][DW-1:0]   cdb_val;

    prf_multiport #(
        .PRF_SIZE (NPR),
        .DATA_W   (DW),
        .NUM_RD   (NRD),
        .NUM_WB   (NWB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_id      (rd_id),
        .rd_valid   (rd_valid),
        .rd_val     (rd_val),
        .wb_ena     (wb_ena),
        .wb_id      (wb_id),
        .wb_val     (wb_val),
        .free_ena   (free_ena),
        .free_id    (free_id),
        .ready_regs (ready_regs),
        .cdb_valid  (cdb_valid),
        .cdb_id     (cdb_id),
        .cdb_val    (cdb_val)
    );

    always #5 clk = ~clk;

`ifdef PRF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    prf_data_t   m_rf [NPR];
    logic [NPR-1:0] m_ready;
    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NPR; r++) m_rf[r] = '0;
        m_ready = '1;
    endtask

    task automatic idle();
        rd_req = '0; rd_id = '0; wb_ena = '0; wb_id = '0; wb_val = '0;
        free_ena = '0; free_id = '0;
    endtask

    // Predict from the current inputs and model, advance one clock, compare all outputs.
    task automatic step();
        logic [NRD-1:0]         e_rv;
        logic [NRD-1:0][DW-1:0] e_rd;
        logic [NWB-1:0]         e_cv;
        logic [NWB-1:0][IW-1:0] e_ci;
        logic [NWB-1:0][DW-1:0] e_cd;
        prf_data_t v;
        for (int k = 0; k < NRD; k++) begin
            v = m_rf[rd_id[k]];
            for (int i = 0; i < NWB; i++)
                if (wb_ena[i] && wb_id[i] == rd_id[k]) v = wb_val[i];
            if (ZR && rd_id[k] == 0) v = '0;
            e_rv[k] = rd_req[k];
            e_rd[k] = rd_req[k] ? v : '0;
        end
        for (int i = 0; i < NWB; i++) begin
            e_cv[i] = wb_ena[i];
            e_ci[i] = wb_ena[i] ? wb_id[i] : '0;
            e_cd[i] = (wb_ena[i] && !(ZR && wb_id[i] == 0)) ? wb_val[i] : '0;
        end
        for (int j = 0; j < NWB; j++)
            if (free_ena[j] && !(ZR && free_id[j] == 0)) m_ready[free_id[j]] = 1'b0;
        for (int i = 0; i < NWB; i++)
            if (wb_ena[i]) begin
                m_ready[wb_id[i]] = 1'b1;
                if (!(ZR && wb_id[i] == 0)) m_rf[wb_id[i]] = wb_val[i];
            end
        @(posedge clk);
        #1;
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rd_valid%0d", k), 64'(rd_valid[k]), 64'(e_rv[k]));
            chk($sformatf("rd_val%0d", k),   64'(rd_val[k]),   64'(e_rd[k]));
        end
        for (int i = 0; i < NWB; i++) begin
            chk($sformatf("cdb_valid%0d", i), 64'(cdb_valid[i]), 64'(e_cv[i]));
            chk($sformatf("cdb_id%0d", i),    64'(cdb_id[i]),    64'(e_ci[i]));
            chk($sformatf("cdb_val%0d", i),   64'(cdb_val[i]),   64'(e_cd[i]));
        end
        chk("ready_regs", 64'(ready_regs), 64'(m_ready));
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        #12 rst = 1'b0;
        #1;
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_val", 64'(rd_val), 64'(0));
        chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        chk("rst_cdb_id", 64'(cdb_id), 64'(0));
        chk("rst_cdb_val", 64'(cdb_val), 64'(0));
        chk("rst_ready", 64'(ready_regs), 64'h0000_0000_FFFF_FFFF);

        // Every register reads back zero after reset.
        for (int r = 0; r < NPR; r++) begin
            rd_req = '1; rd_id[0] = IW'(r); rd_id[1] = IW'(NPR - 1 - r);
            step();
        end
        idle();

        // Write one register while freeing another.
        wb_ena[0] = 1'b1; wb_id[0] = 5'd5; wb_val[0] = 8'hA5;
        free_ena[1] = 1'b1; free_id[1] = 5'd7;
        step();
        idle();
        chk("ready5", 64'(ready_regs[5]), 64'(1));
        chk("ready7", 64'(ready_regs[7]), 64'(0));

        // Same-cycle bypass, then a plain read of the stored value.
        rd_req[1] = 1'b1; rd_id[1] = 5'd9;
        wb_ena[1] = 1'b1; wb_id[1] = 5'd9; wb_val[1] = 8'h3C;
        step();
        chk("bypass9", 64'(rd_val[1]), 64'h3C);
        idle();
        rd_req = 2'b11; rd_id[0] = 5'd9; rd_id[1] = 5'd5;
        step();
        chk("stored9", 64'(rd_val[0]), 64'h3C);
        idle();

        // Dual writes to one id plus a free of that id.
        wb_ena = 2'b11; wb_id[0] = 5'd4; wb_val[0] = 8'h11; wb_id[1] = 5'd4; wb_val[1] = 8'h22;
        free_ena[0] = 1'b1; free_id[0] = 5'd4;
        rd_req[0] = 1'b1; rd_id[0] = 5'd4;
        step();
        chk("wb_conflict_byp", 64'(rd_val[0]), 64'h22);
        idle();
        rd_req[1] = 1'b1; rd_id[1] = 5'd4;
        step();
        chk("wb_conflict_rf", 64'(rd_val[1]), 64'h22);
        chk("ready4", 64'(ready_regs[4]), 64'(1));
        idle();

        // Register 0: write, read, free.
        wb_ena[0] = 1'b1; wb_id[0] = 5'd0; wb_val[0] = 8'hFF;
        rd_req[1] = 1'b1; rd_id[1] = 5'd0;
        step();
        idle();
        rd_req[0] = 1'b1; rd_id[0] = 5'd0;
        free_ena[0] = 1'b1; free_id[0] = 5'd0;
        step();
        idle();
        step();

        // Reset asserted between edges with traffic in flight.
        rd_req = 2'b11; wb_ena = 2'b11; wb_id[0] = 5'd12; wb_id[1] = 5'd13;
        wb_val[0] = 8'h5A; wb_val[1] = 8'hC3; free_ena[0] = 1'b1; free_id[0] = 5'd20;
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_rd_valid", 64'(rd_valid), 64'(0));
        chk("midrst_cdb_valid", 64'(cdb_valid), 64'(0));
        chk("midrst_ready", 64'(ready_regs), 64'h0000_0000_FFFF_FFFF);
        idle();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rd_req = 2'b11; rd_id[0] = 5'd12; rd_id[1] = 5'd13;
        step();
        idle();

        // Random traffic; narrow id range half the time to force collisions.
        for (int n = 0; n < 400; n++) begin
            int hi;
            hi = ($urandom_range(0, 1) != 0) ? 7 : NPR - 1;
            rd_req = 2'($urandom);
            wb_ena = 2'($urandom);
            free_ena = 2'($urandom);
            for (int k = 0; k < NRD; k++) rd_id[k] = IW'($urandom_range(0, hi));
            for (int i = 0; i < NWB; i++) begin
                wb_id[i]   = IW'($urandom_range(0, hi));
                wb_val[i]  = DW'($urandom);
                free_id[i] = IW'($urandom_range(0, hi));
            end
            step();
        end
        idle();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
